// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline control blocks: scoreboard slot,
// SRAM wait states and register-file constants.
package mips_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 8;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
  } slot_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } sram_state_t;

  // A slot produces a register the reader still needs; r0 never counts.
  function automatic logic slot_hit(slot_t s, logic [REG_W-1:0] src);
    return s.valid & s.wb_en & (s.dest != REG_ZERO) & (s.dest == src);
  endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// ID-stage decode attributes and pipeline control returned by the hazard sequencer.
interface hazard_sequencer_if;
  import mips_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_src2_used;
  logic             id_single_src;
  logic [REG_W-1:0] id_dest;
  logic             id_wb_en;
  logic             id_mem_r_en;
  logic             id_mem_w_en;
  logic             br_taken;
  logic             sram_ready;

  logic             hazard_detected;
  logic             freeze_pc;
  logic             freeze_ifid;
  logic             flush_ifid;
  logic             freeze_all;
  logic             sram_error;

  modport master (
    output id_valid, id_src1, id_src2, id_src2_used, id_single_src,
           id_dest, id_wb_en, id_mem_r_en, id_mem_w_en, br_taken, sram_ready,
    input  hazard_detected, freeze_pc, freeze_ifid, flush_ifid, freeze_all, sram_error
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_src2_used, id_single_src,
           id_dest, id_wb_en, id_mem_r_en, id_mem_w_en, br_taken, sram_ready,
    output hazard_detected, freeze_pc, freeze_ifid, flush_ifid, freeze_all, sram_error
  );

endinterface

// File: rtl/sram_wait_fsm.sv
// Sequences one multi-cycle SRAM access in MEM: freezes the pipeline until
// the SRAM acknowledges or the wait budget runs out (sticky error).
module sram_wait_fsm
  import mips_pkg::*;
#(
  parameter int unsigned SRAM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic access,
  input  logic sram_ready,
  output logic freeze_all_c,
  output logic sram_error
);

  sram_state_t      state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_inc;

  // Saturating increment: the counter must never wrap back to zero.
  assign cnt_inc = (wait_cnt == {CNT_W{1'b1}}) ? wait_cnt : wait_cnt + CNT_W'(1);

  // Entry cycle freezes combinationally so MEM cannot slip past a pending access.
  assign freeze_all_c = (state == WAIT) | ((state == IDLE) & access & ~sram_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      sram_error <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access & ~sram_ready) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          wait_cnt <= cnt_inc;
          if (sram_ready) begin
            state <= DONE;
          end else if (cnt_inc >= CNT_W'(SRAM_TIMEOUT)) begin
            state      <= DONE;
            sram_error <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline control for the 5-stage MIPS core: EXE/MEM scoreboard, data-hazard
// detection against ID sources, branch flush and SRAM freeze sequencing.
module hazard_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned FORWARD_EN   = 0,
  parameter int unsigned SRAM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  hazard_sequencer_if.slave  bus
);

  slot_t exe_slot;
  slot_t mem_slot;

  logic chk_src2;
  logic mem_access;
  logic freeze_all_c;
  logic hz_full;
  logic hz_load;
  logic hazard_c;
  logic bubble;

  assign chk_src2   = bus.id_src2_used & ~bus.id_single_src;
  assign mem_access = mem_slot.valid & (mem_slot.mem_r_en | mem_slot.mem_w_en);

  // Without forwarding any in-flight producer stalls; with it only a load in EXE does.
  assign hz_full = slot_hit(exe_slot, bus.id_src1) | slot_hit(mem_slot, bus.id_src1)
                 | (chk_src2 & (slot_hit(exe_slot, bus.id_src2) | slot_hit(mem_slot, bus.id_src2)));
  assign hz_load = exe_slot.mem_r_en
                 & (slot_hit(exe_slot, bus.id_src1) | (chk_src2 & slot_hit(exe_slot, bus.id_src2)));

  assign hazard_c = bus.id_valid & ~bus.br_taken & ((FORWARD_EN != 0) ? hz_load : hz_full);
  assign bubble   = hazard_c | bus.br_taken | ~bus.id_valid;

  assign bus.hazard_detected = hazard_c;
  assign bus.freeze_pc       = hazard_c | freeze_all_c;
  assign bus.freeze_ifid     = hazard_c | freeze_all_c;
  assign bus.flush_ifid      = bus.br_taken & ~freeze_all_c;
  assign bus.freeze_all      = freeze_all_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      exe_slot <= '0;
      mem_slot <= '0;
    end else if (!freeze_all_c) begin
      mem_slot <= exe_slot;
      if (bubble) begin
        exe_slot <= '0;
      end else begin
        exe_slot.valid    <= 1'b1;
        exe_slot.dest     <= bus.id_dest;
        exe_slot.wb_en    <= bus.id_wb_en;
        exe_slot.mem_r_en <= bus.id_mem_r_en;
        exe_slot.mem_w_en <= bus.id_mem_w_en;
      end
    end
  end

  sram_wait_fsm #(
    .SRAM_TIMEOUT (SRAM_TIMEOUT)
  ) u_sram_wait_fsm (
    .clk          (clk),
    .rst          (rst),
    .access       (mem_access),
    .sram_ready   (bus.sram_ready),
    .freeze_all_c (freeze_all_c),
    .sram_error   (bus.sram_error)
  );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: two instances (no forwarding / timeout 3, and
// forwarding / timeout 15) share stimulus and are checked against a reference model.
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_src1;
  logic [4:0] id_src2;
  logic       id_src2_used;
  logic       id_single_src;
  logic [4:0] id_dest;
  logic       id_wb_en;
  logic       id_mem_r_en;
  logic       id_mem_w_en;
  logic       br_taken;
  logic       sram_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_sequencer_if bus0 ();
  hazard_sequencer_if bus1 ();

  assign bus0.id_valid      = id_valid;
  assign bus0.id_src1       = id_src1;
  assign bus0.id_src2       = id_src2;
  assign bus0.id_src2_used  = id_src2_used;
  assign bus0.id_single_src = id_single_src;
  assign bus0.id_dest       = id_dest;
  assign bus0.id_wb_en      = id_wb_en;
  assign bus0.id_mem_r_en   = id_mem_r_en;
  assign bus0.id_mem_w_en   = id_mem_w_en;
  assign bus0.br_taken      = br_taken;
  assign bus0.sram_ready    = sram_ready;

  assign bus1.id_valid      = id_valid;
  assign bus1.id_src1       = id_src1;
  assign bus1.id_src2       = id_src2;
  assign bus1.id_src2_used  = id_src2_used;
  assign bus1.id_single_src = id_single_src;
  assign bus1.id_dest       = id_dest;
  assign bus1.id_wb_en      = id_wb_en;
  assign bus1.id_mem_r_en   = id_mem_r_en;
  assign bus1.id_mem_w_en   = id_mem_w_en;
  assign bus1.br_taken      = br_taken;
  assign bus1.sram_ready    = sram_ready;

  hazard_sequencer #(.FORWARD_EN(0), .SRAM_TIMEOUT(3)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  hazard_sequencer #(.FORWARD_EN(1), .SRAM_TIMEOUT(15)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Output vector: {hazard, freeze_pc, freeze_ifid, flush, freeze_all, sram_error}
  logic [5:0] obs [2];
  assign obs[0] = {bus0.hazard_detected, bus0.freeze_pc, bus0.freeze_ifid,
                   bus0.flush_ifid, bus0.freeze_all, bus0.sram_error};
  assign obs[1] = {bus1.hazard_detected, bus1.freeze_pc, bus1.freeze_ifid,
                   bus1.flush_ifid, bus1.freeze_all, bus1.sram_error};

  // ---------------- reference model ----------------
  typedef struct {
    bit       v;
    bit [4:0] d;
    bit       wb;
    bit       mr;
    bit       mw;
  } ins_t;

  ins_t m_exe  [2];
  ins_t m_mem  [2];
  int   m_wait [2];   // freeze cycles already spent on the access in MEM
  bit   m_done [2];   // access finished, release cycle pending
  bit   m_err  [2];

  function automatic int tmo_of(int d);
    return (d == 0) ? 3 : 15;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_exe[d]  = '{default: 0};
      m_mem[d]  = '{default: 0};
      m_wait[d] = 0;
      m_done[d] = 1'b0;
      m_err[d]  = 1'b0;
    end
  endfunction

  function automatic bit writes_reg(ins_t p, bit [4:0] r);
    return p.v && p.wb && (p.d != 5'd0) && (p.d == r);
  endfunction

  function automatic bit m_access(int d);
    return m_mem[d].v && (m_mem[d].mr || m_mem[d].mw);
  endfunction

  function automatic bit m_freeze(int d);
    if (m_done[d] || !m_access(d)) return 1'b0;
    if (m_wait[d] == 0) return !sram_ready;
    return 1'b1;
  endfunction

  function automatic bit m_hazard(int d);
    bit [4:0] srcs [$];
    ins_t     prods [$];
    bit       hit;
    hit = 1'b0;
    srcs.push_back(id_src1);
    if (id_src2_used && !id_single_src) srcs.push_back(id_src2);
    if (d == 1) begin
      if (m_exe[d].mr) prods.push_back(m_exe[d]);
    end else begin
      prods.push_back(m_exe[d]);
      prods.push_back(m_mem[d]);
    end
    foreach (prods[p])
      foreach (srcs[s])
        if (writes_reg(prods[p], srcs[s])) hit = 1'b1;
    return id_valid && !br_taken && hit;
  endfunction

  function automatic logic [5:0] exp_outs(int d);
    bit fr;
    bit hz;
    fr = m_freeze(d);
    hz = m_hazard(d);
    return {hz, hz | fr, hz | fr, br_taken & !fr, fr, m_err[d]};
  endfunction

  function automatic void model_step();
    bit fr;
    bit hz;
    for (int d = 0; d < 2; d++) begin
      fr = m_freeze(d);
      hz = m_hazard(d);
      if (!rst) begin
        m_exe[d]  = '{default: 0};
        m_mem[d]  = '{default: 0};
        m_wait[d] = 0;
        m_done[d] = 1'b0;
        m_err[d]  = 1'b0;
      end else begin
        if (m_done[d]) begin
          m_done[d] = 1'b0;
          m_wait[d] = 0;
        end else if (m_access(d)) begin
          if (m_wait[d] == 0) begin
            if (!sram_ready) m_wait[d] = 1;
          end else if (sram_ready) begin
            m_done[d] = 1'b1;
          end else if (m_wait[d] >= tmo_of(d)) begin
            m_done[d] = 1'b1;
            m_err[d]  = 1'b1;
          end else begin
            m_wait[d] = m_wait[d] + 1;
          end
        end
        if (!fr) begin
          m_mem[d] = m_exe[d];
          if (hz || br_taken || !id_valid) m_exe[d] = '{default: 0};
          else m_exe[d] = '{v: 1'b1, d: id_dest, wb: id_wb_en, mr: id_mem_r_en, mw: id_mem_w_en};
        end
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid      = 1'b0;
    id_src1       = 5'd0;
    id_src2       = 5'd0;
    id_src2_used  = 1'b0;
    id_single_src = 1'b0;
    id_dest       = 5'd0;
    id_wb_en      = 1'b0;
    id_mem_r_en   = 1'b0;
    id_mem_w_en   = 1'b0;
    br_taken      = 1'b0;
    sram_ready    = 1'b0;
  endtask

  task automatic set_id(input bit v, input bit [4:0] s1, input bit [4:0] s2, input bit s2u,
                        input bit single, input bit [4:0] dst, input bit wb, input bit mr,
                        input bit mw);
    id_valid      = v;
    id_src1       = s1;
    id_src2       = s2;
    id_src2_used  = s2u;
    id_single_src = single;
    id_dest       = dst;
    id_wb_en      = wb;
    id_mem_r_en   = mr;
    id_mem_w_en   = mw;
    br_taken      = 1'b0;
  endtask

  task automatic drain();
    rst = 1'b1;
    set_idle();
    sram_ready = 1'b1;
    repeat (5) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    set_idle();
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== 6'b0) begin
        errors++;
        $display("FAIL reset dut%0d got %b expected %b", d, obs[d], 6'b0);
      end
      checks++;
      if (obs[d] !== exp_outs(d)) begin
        errors++;
        $display("FAIL reset_model dut%0d got %b expected %b", d, obs[d], exp_outs(d));
      end
    end
    tick();
  endtask

  task automatic test_load_use();
    bit hz0 [4] = '{0, 1, 1, 0};
    bit hz1 [4] = '{0, 1, 0, 0};
    drain();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) set_id(1, 5'd1, 5'd2, 0, 0, 5'd5, 1, 1, 0);
      else        set_id(1, 5'd5, 5'd6, 1, 0, 5'd7, 1, 0, 0);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_outs(d)) begin
          errors++;
          $display("FAIL load_use dut%0d cyc%0d got %b expected %b", d, c, obs[d], exp_outs(d));
        end
      end
      checks++;
      if (obs[0][5] !== hz0[c]) begin
        errors++;
        $display("FAIL load_use_nofwd_hz cyc%0d got %b expected %b", c, obs[0][5], hz0[c]);
      end
      checks++;
      if (obs[1][5] !== hz1[c]) begin
        errors++;
        $display("FAIL load_use_fwd_hz cyc%0d got %b expected %b", c, obs[1][5], hz1[c]);
      end
      tick();
    end
  endtask

  task automatic test_src2();
    bit e0;
    for (int v = 0; v < 2; v++) begin
      drain();
      for (int c = 0; c < 4; c++) begin
        if (c == 0) set_id(1, 5'd1, 5'd2, 0, 0, 5'd3, 1, 0, 0);
        else        set_id(1, 5'd1, 5'd3, 1, (v == 1), 5'd8, 1, 0, 0);
        e0 = (v == 0) && (c == 1 || c == 2);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
          checks++;
          if (obs[d] !== exp_outs(d)) begin
            errors++;
            $display("FAIL src2 v%0d dut%0d cyc%0d got %b expected %b", v, d, c, obs[d], exp_outs(d));
          end
        end
        checks++;
        if (obs[0][5] !== e0) begin
          errors++;
          $display("FAIL src2_stall v%0d cyc%0d got %b expected %b", v, c, obs[0][5], e0);
        end
        checks++;
        if (obs[1][5] !== 1'b0) begin
          errors++;
          $display("FAIL src2_fwd v%0d cyc%0d got %b expected 0", v, c, obs[1][5]);
        end
        tick();
      end
    end
  endtask

  task automatic test_r0();
    drain();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) set_id(1, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 0);
      else        set_id(1, 5'd0, 5'd0, 1, 0, 5'd9, 1, 0, 0);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d][5] !== 1'b0 || obs[d] !== exp_outs(d)) begin
          errors++;
          $display("FAIL r0 dut%0d cyc%0d got %b expected %b", d, c, obs[d], exp_outs(d));
        end
      end
      tick();
    end
  endtask

  task automatic test_sram_ready();
    logic [7:0] ef = 8'b0011_1100;
    drain();
    for (int c = 0; c < 8; c++) begin
      if (c == 0) set_id(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1);
      else        set_idle();
      sram_ready = (c == 5);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_outs(d)) begin
          errors++;
          $display("FAIL sram_ready dut%0d cyc%0d got %b expected %b", d, c, obs[d], exp_outs(d));
        end
        checks++;
        if (obs[d][1] !== ef[c] || obs[d][0] !== 1'b0) begin
          errors++;
          $display("FAIL sram_ready_freeze dut%0d cyc%0d got frz=%b err=%b expected frz=%b err=0",
                   d, c, obs[d][1], obs[d][0], ef[c]);
        end
      end
      tick();
    end
  endtask

  task automatic test_sram_timeout();
    logic [7:0] ef = 8'b0011_1100;
    logic       ee;
    drain();
    for (int c = 0; c < 12; c++) begin
      if (c == 0) set_id(1, 5'd1, 5'd2, 0, 0, 5'd4, 1, 1, 0);
      else        set_idle();
      sram_ready = (c >= 8);
      ee = (c >= 6);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_outs(d)) begin
          errors++;
          $display("FAIL timeout dut%0d cyc%0d got %b expected %b", d, c, obs[d], exp_outs(d));
        end
      end
      if (c < 8) begin
        checks++;
        if (obs[0][1] !== ef[c]) begin
          errors++;
          $display("FAIL timeout_freeze cyc%0d got %b expected %b", c, obs[0][1], ef[c]);
        end
      end
      checks++;
      if (obs[0][0] !== ee) begin
        errors++;
        $display("FAIL timeout_error cyc%0d got %b expected %b", c, obs[0][0], ee);
      end
      tick();
    end
  endtask

  task automatic test_branch_reset();
    drain();
    for (int c = 0; c < 5; c++) begin
      rst = 1'b1;
      if (c == 0) begin
        set_id(1, 5'd1, 5'd2, 0, 0, 5'd5, 1, 1, 0);
      end else if (c == 1) begin
        set_id(1, 5'd5, 5'd6, 1, 0, 5'd7, 1, 0, 0);
        br_taken = 1'b1;
      end else begin
        set_idle();
      end
      sram_ready = 1'b0;
      if (c == 3) rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_outs(d)) begin
          errors++;
          $display("FAIL branch_reset dut%0d cyc%0d got %b expected %b", d, c, obs[d], exp_outs(d));
        end
        if (c == 1) begin
          checks++;
          if (obs[d][2] !== 1'b1 || obs[d][5] !== 1'b0) begin
            errors++;
            $display("FAIL branch_wins dut%0d got flush=%b hz=%b expected flush=1 hz=0",
                     d, obs[d][2], obs[d][5]);
          end
        end else if (c == 2 || c == 3) begin
          checks++;
          if (obs[d][1] !== 1'b1) begin
            errors++;
            $display("FAIL branch_wait dut%0d cyc%0d got frz=%b expected 1", d, c, obs[d][1]);
          end
        end else if (c == 4) begin
          checks++;
          if (obs[d] !== 6'b0) begin
            errors++;
            $display("FAIL reset_in_wait dut%0d got %b expected %b", d, obs[d], 6'b0);
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 99) != 0);
      id_valid      = ($urandom_range(0, 9) < 8);
      id_src1       = 5'($urandom_range(0, 4));
      id_src2       = 5'($urandom_range(0, 4));
      id_src2_used  = $urandom_range(0, 1) == 1;
      id_single_src = ($urandom_range(0, 4) == 0);
      id_dest       = 5'($urandom_range(0, 4));
      id_wb_en      = ($urandom_range(0, 9) < 7);
      id_mem_r_en   = ($urandom_range(0, 9) < 3);
      id_mem_w_en   = ($urandom_range(0, 9) < 2);
      br_taken      = ($urandom_range(0, 9) == 0);
      sram_ready    = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_outs(d)) begin
          errors++;
          $display("FAIL random dut%0d iter%0d got %b expected %b", d, i, obs[d], exp_outs(d));
        end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    set_idle();
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_src2();
    test_r0();
    test_sram_ready();
    test_sram_timeout();
    test_branch_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
